// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write bus between the boot source and rom_loader.
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic                  core_hold;
  logic                  done;
  logic                  err;

  // Boot source side: drives the stream, observes ROM writes and status.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, core_hold, done, err
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, core_hold, done, err
  );
endinterface

// File: rtl/rom_loader.sv
// Boot-time ROM writer: framed byte stream (length, payload, checksum) in,
// little-endian 32-bit ROM writes out; holds the core in reset until the
// image is loaded and its XOR checksum matches.
//
// state  | meaning
// S_LEN  | collecting 4-byte little-endian word count N
// S_DATA | collecting payload, one ROM write per 4 bytes
// S_CSUM | waiting for the XOR checksum byte
// S_DONE | image verified, core released (terminal)
// S_ERR  | bad length or checksum, core held (terminal)
module rom_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic         clk,
  input  logic         rst,
  rom_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           asm_q, asm_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [7:0]            csum_q, csum_d;
  logic                  accept;

  // Next-state and next-output logic. Bytes shift in from the top so that
  // after four accepts the first byte sits in bits [7:0] (little-endian).
  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    len_d      = len_q;
    asm_d      = asm_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    accept     = bus.in_valid && ready_q;

    case (state_q)
      S_LEN: begin
        if (accept) begin
          len_d      = {bus.in_data, len_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Full 32-bit compare so huge counts cannot alias into range.
            if (len_d == 32'd0 || len_d > DEPTH_W) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d    = S_DATA;
              word_idx_d = '0;
              csum_d     = 8'h00;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ bus.in_data;
          asm_d      = {bus.in_data, asm_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = word_idx_q;
            wdata_d = asm_d;
            if (32'(word_idx_q) == len_q - 32'd1) begin
              state_d = S_CSUM;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase

    ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  // State and registered outputs; reset also cancels any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'h0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= 32'h0;
      asm_q      <= 32'h0;
      byte_idx_q <= 2'd0;
      word_idx_q <= '0;
      csum_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.core_hold = hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
